// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare/lui, with
// iterative shifts at SHIFT_STEP bits per cycle. Busy stalls the pipe.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   InValid  in   operation presented this cycle
//   InReady  out  block can accept (= !Busy)
//   Select   in   4-bit op code from ALU control
//   A, B     in   operands; B[4:0] is the shift amount
//   Flush    in   synchronous abort
//   Result   out  registered result
//   Zero     out  registered (Result == 0)
//   OutValid out  one-cycle pulse marking a new Result
//   Busy     out  iterative shift in progress
module multicycle_alu #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       Select,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             OutValid,
    output logic             Busy
);

    generate
        if (WIDTH != 32 ||
            !(SHIFT_STEP == 1 || SHIFT_STEP == 2 ||
              SHIFT_STEP == 4 || SHIFT_STEP == 8 ||
              SHIFT_STEP == 16 || SHIFT_STEP == 32)) begin : g_bad_params
            $error("multicycle_alu: unsupported WIDTH or SHIFT_STEP");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Shift kinds, taken from Select[1:0] of the shift codes.
    localparam logic [1:0] SK_SLL = 2'b00;
    localparam logic [1:0] SK_SRL = 2'b01;
    localparam logic [1:0] SK_SRA = 2'b10;

    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             outvalid_q;
    logic [WIDTH-1:0] work_q;
    logic [5:0]       rem_q;
    logic [1:0]       kind_q;

    logic [WIDTH-1:0] alu_d;
    logic [WIDTH-1:0] shift_d;
    logic [5:0]       step_amt;
    logic [4:0]       shamt;
    logic             is_shift;
    logic             accept;
    logic             slt_lt;
    logic             sltu_lt;

    assign Busy     = (state_q == SHIFT);
    assign InReady  = !Busy;
    assign Result   = result_q;
    assign Zero     = zero_q;
    assign OutValid = outvalid_q;

    assign shamt    = B[4:0];
    assign accept   = InValid && InReady && !Flush;
    assign is_shift = (Select == 4'b1000) ||
                      (Select == 4'b1001) ||
                      (Select == 4'b1010);
    assign slt_lt   = $signed(A) < $signed(B);
    assign sltu_lt  = A < B;

    // Single-cycle result. A zero-length shift returns A directly.
    always_comb begin
        alu_d = '0;
        unique case (Select)
            4'b0000: alu_d = A + B;
            4'b0001: alu_d = A - B;
            4'b0011: alu_d = B;
            4'b0100: alu_d = A | B;
            4'b0101: alu_d = A & B;
            4'b0111: alu_d = A ^ B;
            4'b1101: alu_d = {{(WIDTH-1){1'b0}}, slt_lt};
            4'b1111: alu_d = {{(WIDTH-1){1'b0}}, sltu_lt};
            4'b1000: alu_d = A;
            4'b1001: alu_d = A;
            4'b1010: alu_d = A;
            default: alu_d = '0;
        endcase
    end

    // One iteration: shift by min(remaining, SHIFT_STEP).
    assign step_amt = (rem_q > STEP) ? STEP : rem_q;

    always_comb begin
        shift_d = work_q;
        unique case (kind_q)
            SK_SLL:  shift_d = work_q << step_amt;
            SK_SRL:  shift_d = work_q >> step_amt;
            SK_SRA:  shift_d = $signed(work_q) >>> step_amt;
            default: shift_d = work_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            result_q   <= '0;
            zero_q     <= 1'b1;
            outvalid_q <= 1'b0;
            work_q     <= '0;
            rem_q      <= '0;
            kind_q     <= SK_SLL;
        end else begin
            outvalid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_shift && shamt != 5'd0) begin
                            state_q <= SHIFT;
                            work_q  <= A;
                            rem_q   <= {1'b0, shamt};
                            kind_q  <= Select[1:0];
                        end else begin
                            result_q   <= alu_d;
                            zero_q     <= (alu_d == '0);
                            outvalid_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (Flush) begin
                        // Abort: drop the shift, keep the old Result.
                        state_q <= IDLE;
                        rem_q   <= '0;
                    end else begin
                        work_q <= shift_d;
                        rem_q  <= rem_q - step_amt;
                        if (rem_q == step_amt) begin
                            state_q    <= IDLE;
                            result_q   <= shift_d;
                            zero_q     <= (shift_d == '0);
                            outvalid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: directed plan steps plus random ops
// against a plain-arithmetic reference model, SHIFT_STEP 1 and 4.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  Select = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;

    logic        InValid = 1'b0, Flush = 1'b0;
    logic        InReady, Zero, OutValid, Busy;
    logic [31:0] Result;

    logic        InValid4 = 1'b0, Flush4 = 1'b0;
    logic        InReady4, Zero4, OutValid4, Busy4;
    logic [31:0] Result4;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
        .Select(Select), .A(A), .B(B), .Flush(Flush),
        .Result(Result), .Zero(Zero), .OutValid(OutValid), .Busy(Busy)
    );

    multicycle_alu #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .InValid(InValid4), .InReady(InReady4),
        .Select(Select), .A(A), .B(B), .Flush(Flush4),
        .Result(Result4), .Zero(Zero4), .OutValid(OutValid4), .Busy(Busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] s,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        logic [31:0] r;
        sh = int'(b[4:0]);
        case (s)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd3:  r = b;
            4'd4:  r = a | b;
            4'd5:  r = a & b;
            4'd7:  r = a ^ b;
            4'd13: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd15: r = (a < b) ? 32'd1 : 32'd0;
            4'd8:  r = a << sh;
            4'd9:  r = a >> sh;
            4'd10: r = $signed(a) >>> sh;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [3:0] s,
                                   input logic [31:0] b, input int step);
        int sh;
        sh = int'(b[4:0]);
        if ((s == 4'd8 || s == 4'd9 || s == 4'd10) && sh != 0)
            return 1 + (sh + step - 1) / step;
        return 1;
    endfunction

    // Called at a negedge; returns at the negedge of the OutValid cycle.
    task automatic do_op(input bit w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [31:0] exp;
        int lat, cyc;
        logic ov;
        exp = ref_alu(s, a, b);
        lat = exp_lat(s, b, w ? 4 : 1);
        Select = s; A = a; B = b;
        check({tag, " ready"}, w ? InReady4 : InReady, 1);
        if (w) InValid4 = 1'b1; else InValid = 1'b1;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (w) InValid4 = 1'b0;
            ov = w ? OutValid4 : OutValid;
            if (ov || cyc > 40) break;
            check({tag, " busy"}, w ? Busy4 : Busy, 1);
            check({tag, " inready low"}, w ? InReady4 : InReady, 0);
            if (!w) begin
                // Inputs during a shift must be ignored.
                InValid = 1'($urandom_range(0, 1));
                A = $urandom; B = $urandom;
                Select = 4'($urandom_range(0, 15));
            end
        end
        InValid = 1'b0;
        InValid4 = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " result"}, w ? Result4 : Result, exp);
        check({tag, " zero"}, w ? Zero4 : Zero, exp == 32'd0);
        check({tag, " busy done"}, w ? Busy4 : Busy, 0);
        if (!w) last_res = exp;
    endtask

    initial begin
        logic [3:0]  s;
        logic [31:0] a, b, e;
        logic [31:0] exp_q[$];
        logic [3:0]  single_ops[13];
        single_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                       4'd7, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

        #1 rst = 1'b0;
        #1;
        check("reset result", Result, 32'd0);
        check("reset zero", Zero, 1);
        check("reset outvalid", OutValid, 0);
        check("reset busy", Busy, 0);
        check("reset inready", InReady, 1);
        check("reset busy4", Busy4, 0);
        @(negedge clk);
        rst = 1'b1;

        do_op(0, 4'd0, 32'hFFFF_FFFF, 32'd1, "add wrap");
        @(negedge clk);
        check("add pulse end", OutValid, 0);
        do_op(0, 4'd1, 32'd5, 32'd7, "sub");
        do_op(0, 4'd13, 32'd5, 32'd7, "slt 5 7");
        do_op(0, 4'd13, 32'hFFFF_FFFF, 32'd1, "slt neg");
        do_op(0, 4'd15, 32'hFFFF_FFFF, 32'd1, "sltu");
        do_op(0, 4'd8, 32'd1, 32'd5, "sll step1");
        do_op(0, 4'd0, 32'd3, 32'd4, "add after shift");
        do_op(0, 4'd10, 32'h8000_0000, 32'd31, "sra 31");
        do_op(0, 4'd9, 32'h8000_0000, 32'd31, "srl 31");
        do_op(0, 4'd8, 32'hDEAD_BEEF, 32'h20, "sll shamt0");
        do_op(0, 4'd6, 32'h1234, 32'h5678, "unused 0110");
        do_op(1, 4'd8, 32'd1, 32'd5, "sll step4");
        do_op(1, 4'd10, 32'h8000_0000, 32'd31, "sra step4");
        do_op(1, 4'd9, 32'hF000_000F, 32'd4, "srl step4 exact");

        // Flush in cycle 2 of a 5-bit sll.
        do_op(0, 4'd3, 32'd0, 32'hCAFE_0000, "lui pre flush");
        @(negedge clk);
        Select = 4'd8; A = 32'd1; B = 32'd5; InValid = 1'b1;
        @(negedge clk);
        InValid = 1'b0;
        @(negedge clk);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        check("flush busy", Busy, 0);
        check("flush outvalid", OutValid, 0);
        check("flush result", Result, last_res);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush no late out", OutValid, 0);
        end
        Select = 4'd0; A = 32'd1; B = 32'd2;
        InValid = 1'b1; Flush = 1'b1;
        @(negedge clk);
        InValid = 1'b0; Flush = 1'b0;
        @(negedge clk);
        check("flushed add out", OutValid, 0);
        check("flushed add result", Result, last_res);

        // Streaming single-cycle ops, one per cycle.
        for (int i = 0; i < 10; i++) begin
            s = single_ops[$urandom_range(0, 12)];
            a = $urandom; b = $urandom;
            if (i == 3) b = a;
            Select = s; A = a; B = b; InValid = 1'b1;
            exp_q.push_back(ref_alu(s, a, b));
            @(negedge clk);
            e = exp_q.pop_front();
            check("stream outvalid", OutValid, 1);
            check("stream result", Result, e);
            check("stream zero", Zero, e == 32'd0);
        end
        InValid = 1'b0;
        last_res = e;

        // Random ops on both step sizes.
        for (int i = 0; i < 40; i++) begin
            s = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
            do_op(i[0], s, a, b, "random");
        end

        // Reset during a shift.
        do_op(0, 4'd3, 32'd0, 32'hABCD_0000, "lui pre reset");
        Select = 4'd8; A = 32'd1; B = 32'd20; InValid = 1'b1;
        @(negedge clk);
        InValid = 1'b0;
        @(negedge clk);
        check("pre reset busy", Busy, 1);
        #2 rst = 1'b0;
        #1;
        check("mid reset busy", Busy, 0);
        check("mid reset outvalid", OutValid, 0);
        check("mid reset result", Result, 32'd0);
        check("mid reset zero", Zero, 1);
        @(negedge clk);
        rst = 1'b1;
        do_op(0, 4'd3, 32'd0, 32'h1234_5000, "lui after reset");
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
